// File: rtl/pulse_capture_32bit_if.sv
// Measurement handshake between pulse_capture_32bit (master) and its consumer (slave).
// The master presents period/high_time with meas_valid; the slave accepts with meas_ack.

interface pulse_capture_32bit_if;
  logic        meas_valid;
  logic        meas_ack;
  logic [31:0] period;
  logic [31:0] high_time;

  modport master (
    output meas_valid,
    output period,
    output high_time,
    input  meas_ack
  );

  modport slave (
    input  meas_valid,
    input  period,
    input  high_time,
    output meas_ack
  );
endinterface

// File: rtl/pulse_capture_32bit.sv
// Measures period and high time of an asynchronous pulse train in clock cycles.
// Define PULSE_CAPTURE_GLITCH_FILTER_EN to add a FILTER_LEN-cycle stability filter on the input.

module pulse_capture_32bit #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_sig_in,
  input  logic [31:0]           i_timeout_cycles,
  pulse_capture_32bit_if.master meas,
  output logic                  o_overrun,
  output logic                  o_timeout,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1) begin : g_paramCheck
    $error("pulse_capture_32bit: SYNC_STAGES must be 2..4 and FILTER_LEN at least 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   w_f;

  always_ff @(posedge clock) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam int SETTLE = SYNC_STAGES + FILTER_LEN;

  logic [FCNT_W-1:0] r_filtCnt;
  logic              r_filt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_filtCnt <= '0;
      r_filt    <= 1'b0;
    end else if (w_s == r_filt) begin
      r_filtCnt <= '0;
    end else if (r_filtCnt == FCNT_LAST) begin
      r_filt    <= w_s;
      r_filtCnt <= '0;
    end else begin
      r_filtCnt <= r_filtCnt + 1'b1;
    end
  end

  assign w_f = r_filt;
`else
  localparam int SETTLE = SYNC_STAGES;

  assign w_f = w_s;
`endif

  // The input pipeline holds reset zeros for SETTLE cycles after release; IDLE must not
  // mistake those for a real low level or the first high time would be truncated.
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SETTLE_DONE = SET_W'(SETTLE);

  logic [SET_W-1:0] r_settle;
  logic             w_settled;

  always_ff @(posedge clock) begin
    if (!reset)          r_settle <= '0;
    else if (!w_settled) r_settle <= r_settle + 1'b1;
  end

  assign w_settled = (r_settle == SETTLE_DONE);

  logic r_fPrev;
  logic w_rise;
  logic w_fall;

  always_ff @(posedge clock) begin
    if (!reset) r_fPrev <= 1'b0;
    else        r_fPrev <= w_f;
  end

  assign w_rise = w_f & ~r_fPrev;
  assign w_fall = ~w_f & r_fPrev;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_pCnt;
  logic [31:0] r_hCnt;
  logic [31:0] w_pNext;
  logic [31:0] w_hNext;
  logic [31:0] w_pInc;
  logic [31:0] w_hInc;
  logic        w_measLoad;
  logic        w_timeoutHit;
  logic        w_timeoutMatch;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  assign w_pInc = (r_pCnt == 32'hFFFF_FFFF) ? r_pCnt : r_pCnt + 32'd1;
  assign w_hInc = (r_hCnt == 32'hFFFF_FFFF) ? r_hCnt : r_hCnt + 32'd1;
  assign w_timeoutMatch = (i_timeout_cycles != 32'd0) && (r_pCnt == i_timeout_cycles);

  // Timeout takes priority over edges so a stuck input can never hold the FSM busy.
  always_comb begin
    w_stateNext  = r_state;
    w_pNext      = r_pCnt;
    w_hNext      = r_hCnt;
    w_measLoad   = 1'b0;
    w_timeoutHit = 1'b0;
    case (r_state)
      IDLE: begin
        w_pNext = 32'd0;
        w_hNext = 32'd0;
        if (w_settled && !w_f) w_stateNext = ARMED;
      end
      ARMED: begin
        if (w_rise) begin
          w_stateNext = HIGH;
          w_pNext     = 32'd1;
          w_hNext     = 32'd1;
        end
      end
      HIGH: begin
        if (w_timeoutMatch) begin
          w_stateNext  = IDLE;
          w_pNext      = 32'd0;
          w_hNext      = 32'd0;
          w_timeoutHit = 1'b1;
        end else if (w_fall) begin
          w_stateNext = LOW;
          w_pNext     = w_pInc;
        end else begin
          w_pNext = w_pInc;
          w_hNext = w_hInc;
        end
      end
      LOW: begin
        if (w_timeoutMatch) begin
          w_stateNext  = IDLE;
          w_pNext      = 32'd0;
          w_hNext      = 32'd0;
          w_timeoutHit = 1'b1;
        end else if (w_rise) begin
          w_stateNext = HIGH;
          w_measLoad  = 1'b1;
          w_pNext     = 32'd1;
          w_hNext     = 32'd1;
        end else begin
          w_pNext = w_pInc;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_pNext     = 32'd0;
        w_hNext     = 32'd0;
      end
    endcase
  end

  logic        r_measValid;
  logic [31:0] r_period;
  logic [31:0] r_highTime;
  logic        r_overrun;
  logic        r_timeout;

  // A new result always wins over an ack; overrun flags only results lost unacknowledged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pCnt      <= 32'd0;
      r_hCnt      <= 32'd0;
      r_measValid <= 1'b0;
      r_period    <= 32'd0;
      r_highTime  <= 32'd0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_pCnt    <= w_pNext;
      r_hCnt    <= w_hNext;
      r_timeout <= w_timeoutHit;
      if (w_measLoad) begin
        r_period    <= r_pCnt;
        r_highTime  <= r_hCnt;
        r_measValid <= 1'b1;
        if (r_measValid && !meas.meas_ack) r_overrun <= 1'b1;
      end else if (meas.meas_ack) begin
        r_measValid <= 1'b0;
      end
    end
  end

  assign meas.meas_valid = r_measValid;
  assign meas.period     = r_period;
  assign meas.high_time  = r_highTime;
  assign o_overrun       = r_overrun;
  assign o_timeout       = r_timeout;
  assign o_busy          = (r_state == HIGH) || (r_state == LOW);

endmodule

// File: tb/tb_pulse_capture_32bit.sv
// Self-checking bench for pulse_capture_32bit: scoreboard of expected measurements
// plus directed scenario tasks; glitch expectations follow PULSE_CAPTURE_GLITCH_FILTER_EN.

module tb_pulse_capture_32bit;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + FILTER_LEN;
`else
  localparam int LAT = SYNC_STAGES;
`endif

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] high;
  } meas_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sig_in = 1'b0;
  logic [31:0] timeout_cycles = 32'd0;
  logic        overrun;
  logic        timeout;
  logic        busy;

  pulse_capture_32bit_if meas_if ();

  pulse_capture_32bit #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .i_sig_in         (sig_in),
    .i_timeout_cycles (timeout_cycles),
    .meas             (meas_if.master),
    .o_overrun        (overrun),
    .o_timeout        (timeout),
    .o_busy           (busy)
  );

  always #5 clock = ~clock;

  meas_t expQ[$];
  int    checks = 0;
  int    errors = 0;
  bit    autoAck = 1'b0;

  // One clock step; in autoAck mode every fresh measurement is scored and acknowledged.
  task automatic tick();
    meas_t e;
    @(posedge clock);
    #1;
    if (autoAck) begin
      if (meas_if.meas_ack) begin
        meas_if.meas_ack = 1'b0;
      end else if (meas_if.meas_valid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_meas: got period=%0d high_time=%0d, required no measurement",
                   meas_if.period, meas_if.high_time);
        end else begin
          e = expQ.pop_front();
          if ({meas_if.period, meas_if.high_time} !== {e.period, e.high}) begin
            errors++;
            $display("[TB] FAIL meas_value: got period=%0d high_time=%0d, required period=%0d high_time=%0d",
                     meas_if.period, meas_if.high_time, e.period, e.high);
          end
        end
        meas_if.meas_ack = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic level, input int n);
    sig_in = level;
    repeat (n) tick();
  endtask

  task automatic doReset(input logic level);
    autoAck          = 1'b0;
    meas_if.meas_ack = 1'b0;
    timeout_cycles   = 32'd0;
    sig_in           = level;
    reset            = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    expQ.delete();
  endtask

  task automatic test_reset();
    meas_if.meas_ack = 1'b0;
    sig_in = 1'b0;
    reset  = 1'b0;
    tick();
    tick();
    checks++;
    if (meas_if.meas_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b, required 0", meas_if.meas_valid);
    end
    checks++;
    if (meas_if.period !== 32'd0 || meas_if.high_time !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_data: got period=%0d high_time=%0d, required 0/0",
                         meas_if.period, meas_if.high_time);
    end
    checks++;
    if ({overrun, timeout, busy} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags: got overrun/timeout/busy=%b, required 000",
                         {overrun, timeout, busy});
    end
    reset = 1'b1;
  endtask

  task automatic test_square_wave();
    doReset(1'b0);
    autoAck = 1'b1;
    drive(1'b0, 8);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) expQ.push_back('{period: 32'd8, high: 32'd3});
      drive(1'b1, 3);
      drive(1'b0, 5);
    end
    drive(1'b0, 4);
    checks++;
    if (expQ.size() !== 0) begin
      errors++; $display("[TB] FAIL square_missing: got %0d outstanding, required 0", expQ.size());
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("[TB] FAIL square_overrun: got %b, required 0", overrun);
    end
  endtask

  task automatic test_high_at_reset();
    doReset(1'b1);
    autoAck = 1'b1;
    drive(1'b1, 5);
    drive(1'b0, 10);
    drive(1'b1, 4);
    drive(1'b0, 6);
    expQ.push_back('{period: 32'd10, high: 32'd4});
    drive(1'b1, 4);
    drive(1'b0, 8);
    checks++;
    if (expQ.size() !== 0) begin
      errors++; $display("[TB] FAIL high_at_reset_missing: got %0d outstanding, required 0", expQ.size());
    end
  endtask

  task automatic test_overrun();
    doReset(1'b0);
    drive(1'b0, 8);
    drive(1'b1, 4);
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 6);
    drive(1'b1, 4);
    drive(1'b0, 5);
    checks++;
    if ({meas_if.meas_valid, overrun} !== 2'b11 || meas_if.period !== 32'd10 || meas_if.high_time !== 32'd4) begin
      errors++; $display("[TB] FAIL overrun_second: got valid=%b overrun=%b period=%0d high_time=%0d, required 1 1 10 4",
                         meas_if.meas_valid, overrun, meas_if.period, meas_if.high_time);
    end
    sig_in = 1'b1;
    repeat (LAT) tick();
    meas_if.meas_ack = 1'b1;
    tick();
    meas_if.meas_ack = 1'b0;
    checks++;
    if ({meas_if.meas_valid, overrun} !== 2'b11 || meas_if.period !== 32'd9 || meas_if.high_time !== 32'd4) begin
      errors++; $display("[TB] FAIL ack_with_new: got valid=%b overrun=%b period=%0d high_time=%0d, required 1 1 9 4",
                         meas_if.meas_valid, overrun, meas_if.period, meas_if.high_time);
    end
    meas_if.meas_ack = 1'b1;
    tick();
    meas_if.meas_ack = 1'b0;
    checks++;
    if ({meas_if.meas_valid, overrun} !== 2'b01) begin
      errors++; $display("[TB] FAIL ack_clear: got valid/overrun=%b, required 01", {meas_if.meas_valid, overrun});
    end
  endtask

  task automatic test_timeout();
    int firstTick;
    int pulses;
    doReset(1'b0);
    timeout_cycles = 32'd20;
    drive(1'b0, 8);
    drive(1'b1, 4);
    drive(1'b0, 6);
    sig_in    = 1'b1;
    firstTick = 0;
    pulses    = 0;
    for (int t = 1; t <= 45; t++) begin
      tick();
      if (t == 4) sig_in = 1'b0;
      if (timeout) begin
        pulses++;
        if (firstTick == 0) begin
          firstTick = t;
          checks++;
          if (busy !== 1'b0 || meas_if.meas_valid !== 1'b1 || meas_if.period !== 32'd10 || meas_if.high_time !== 32'd4) begin
            errors++; $display("[TB] FAIL timeout_state: got busy=%b valid=%b period=%0d high_time=%0d, required 0 1 10 4",
                               busy, meas_if.meas_valid, meas_if.period, meas_if.high_time);
          end
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("[TB] FAIL timeout_width: got %0d cycles, required 1", pulses);
    end
    checks++;
    if (firstTick !== LAT + 21) begin
      errors++; $display("[TB] FAIL timeout_time: got tick %0d, required %0d", firstTick, LAT + 21);
    end
    timeout_cycles = 32'd0;
    sig_in = 1'b1;
    pulses = 0;
    for (int t = 1; t <= 44; t++) begin
      tick();
      if (t == 4) sig_in = 1'b0;
      if (timeout) pulses++;
    end
    checks++;
    if (pulses !== 0 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_disabled: got pulses=%0d busy=%b, required 0 1", pulses, busy);
    end
  endtask

  task automatic test_reset_mid_low();
    doReset(1'b0);
    autoAck = 1'b1;
    drive(1'b0, 8);
    drive(1'b1, 4);
    drive(1'b0, 3);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset_busy: got %b, required 1", busy);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({meas_if.meas_valid, overrun, timeout, busy} !== 4'b0000 || meas_if.period !== 32'd0) begin
      errors++; $display("[TB] FAIL mid_reset: got valid/overrun/timeout/busy=%b period=%0d, required 0000 0",
                         {meas_if.meas_valid, overrun, timeout, busy}, meas_if.period);
    end
    drive(1'b0, 8);
    drive(1'b1, 5);
    drive(1'b0, 4);
    expQ.push_back('{period: 32'd9, high: 32'd5});
    drive(1'b1, 5);
    drive(1'b0, 8);
    checks++;
    if (expQ.size() !== 0) begin
      errors++; $display("[TB] FAIL after_reset_missing: got %0d outstanding, required 0", expQ.size());
    end
  endtask

  task automatic test_glitch();
    doReset(1'b0);
    autoAck = 1'b1;
    drive(1'b0, 8);
    drive(1'b1, 6);
    drive(1'b0, 4);
`ifndef PULSE_CAPTURE_GLITCH_FILTER_EN
    expQ.push_back('{period: 32'd10, high: 32'd6});
`endif
    drive(1'b1, 2);
    drive(1'b0, 4);
`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
    expQ.push_back('{period: 32'd16, high: 32'd6});
`else
    expQ.push_back('{period: 32'd6, high: 32'd2});
`endif
    drive(1'b1, 6);
    drive(1'b0, 10);
    checks++;
    if (expQ.size() !== 0) begin
      errors++; $display("[TB] FAIL glitch_missing: got %0d outstanding, required 0", expQ.size());
    end
  endtask

  initial begin
    meas_if.meas_ack = 1'b0;
    test_reset();
    test_square_wave();
    test_high_at_reset();
    test_overrun();
    test_timeout();
    test_reset_mid_low();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_capture_32bit.md
Name: pulse_capture_32bit

Overview:
- Measures period and high time of an external pulse train (wheel encoder, ultrasonic echo, RC PWM) in clock cycles.
- Capture-side counterpart of the rover's free-running period counters.
- Syncs the asynchronous input and times consecutive rising edges.
- Presents each complete measurement on a valid/ack interface to the control logic.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count on sig_in (legal 2..4).
- FILTER_LEN, 4, glitch filter stability window in cycles (used only with the optional feature).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low.
- sig_in  input  1  asynchronous pulse input.
- timeout_cycles  input  32  max cycles without a rising edge; 0 disables timeout.
- meas_ack  input  1  consumer accepts current measurement.
- meas_valid  output  1  measurement pending.
- period  output  32  cycles between consecutive rising edges.
- high_time  output  32  cycles sig high within that period.
- overrun  output  1  sticky: measurement overwritten while unacknowledged.
- timeout  output  1  one-cycle pulse on timeout abort.
- busy  output  1  high in states HIGH and LOW.

Behaviour:
- Reset: clock, reset as decided (reset synchronous, active-low; clock clock). While reset=0 on a clock edge:
  - state=IDLE; sync flops, counters, period, high_time = 0.
  - meas_valid, overrun, timeout, busy = 0.
  - Reset mid-measurement discards the partial count; no output is produced for it.
- Sync: s = last synchronizer stage; s_prev = s delayed one cycle. rise = s & !s_prev; fall = !s & s_prev.
- States:
  - IDLE: wait for s=0, then ARMED. Prevents a truncated first high time when the input is high at reset release.
  - ARMED: on rise, go to HIGH; p_cnt=1, h_cnt=1. No measurement emitted.
  - HIGH: each cycle p_cnt++ and h_cnt++. On fall, go to LOW and increment p_cnt only.
  - LOW: each cycle p_cnt++.
    - On rise: period<=p_cnt, high_time<=h_cnt, meas_valid<=1; then p_cnt=1, h_cnt=1, go to HIGH.
- Example: high 3 cycles, low 5 cycles gives period=8, high_time=3.
- Latency: meas_valid rises on the clock edge ending the rise-detect cycle, i.e. SYNC_STAGES+1 cycles after the sig_in edge.
- Counter width/saturation:
  - p_cnt and h_cnt are 32-bit and saturate at 32'hFFFF_FFFF; no wrap.
  - Saturated values are reported as-is.
- Timeout: in HIGH or LOW, if timeout_cycles!=0 and p_cnt==timeout_cycles:
  - go to IDLE; timeout=1 for exactly one cycle.
  - counters cleared; period/high_time/meas_valid unchanged.
  - timeout_cycles changing mid-measurement takes effect immediately; equality compare only.
- Handshake:
  - meas_valid stays high until a cycle with meas_ack=1, then clears next edge. meas_ack while meas_valid=0 is ignored.
  - New measurement while meas_valid=1 and meas_ack=0: data overwritten, meas_valid stays 1, overrun<=1.
  - New measurement in the same cycle as meas_ack=1: new data loaded, meas_valid stays 1, overrun unchanged.
  - overrun is cleared only by reset.
- busy = (state==HIGH || state==LOW).

Optional Feature:
- Macro: PULSE_CAPTURE_GLITCH_FILTER_EN.
- Defined:
  - A filtered level f replaces s in all edge and state logic.
  - f takes the value of s only after s has held a new value for FILTER_LEN consecutive cycles.
  - Pulses shorter than FILTER_LEN are ignored.
  - Latency grows by FILTER_LEN cycles; the filter counter resets to 0 and f resets to 0.
- Undefined: f = s, no filter logic synthesized, FILTER_LEN unused.

Test Plan:
- Square wave, 3 high / 5 low, 4 periods, meas_ack pulsed after each valid -> 3 measurements of period=8, high_time=3. First rise only arms; overrun=0.
- sig_in held high through reset release, then 10 low, 4 high, 6 low, rise -> no measurement until the first full cycle; then period=10, high_time=4.
- Two measurements without meas_ack -> second values visible, meas_valid=1, overrun=1. Next new measurement with meas_ack=1 in the same cycle -> meas_valid stays 1, overrun stays 1.
- timeout_cycles=20, sig_in stuck low after one rise -> timeout pulse exactly 1 cycle when p_cnt=20; state IDLE; busy=0; meas_valid unchanged. Then timeout_cycles=0 with input stuck -> no timeout, busy stays 1.
- reset=0 for 1 cycle mid-LOW -> all outputs 0 next edge; the following complete cycle measures correctly from ARMED.
- With PULSE_CAPTURE_GLITCH_FILTER_EN, FILTER_LEN=4: a 2-cycle high glitch inside the low phase of a 6 high / 10 low wave -> ignored, period=16, high_time=6. Without the macro the same stimulus yields an extra short measurement.
